rv32_instr_encoder: RTL

Inverse of the decode-side ALU control path: accepts symbolic instruction requests (class, op, rd, rs1, rs2, imm) and produces RV32I 32-bit instruction words.
Words are emitted with a sequential word address for loading into instruction memory by the boot/program loader and by test infrastructure.
Single registered output stage with valid/ready handshake on both sides, a write-address counter with a full limit, and sticky illegal-request reporting.

---
 rtl/rv32_enc_pkg.sv | 91 +++++++++
 rtl/rv32_instr_encoder_if.sv | 27 ++
 rtl/rv32_field_pack.sv | 107 ++++++++++
 rtl/rv32_instr_encoder.sv | 121 ++++++++++++
 4 files changed

// File: rtl/rv32_enc_pkg.sv
// Shared RV32I encoding constants: class/op codes, opcodes, funct fields.
// The decode side imports the same op-code constants.
package rv32_enc_pkg;

  typedef enum logic [2:0] {
    ClsR = 3'd0,
    ClsI = 3'd1,
    ClsL = 3'd2,
    ClsS = 3'd3,
    ClsB = 3'd4
  } enc_class_e;

  localparam logic [3:0] ROpAdd = 4'd1;
  localparam logic [3:0] ROpSub = 4'd2;
  localparam logic [3:0] ROpSll = 4'd3;
  localparam logic [3:0] ROpSlt = 4'd4;
  localparam logic [3:0] ROpXor = 4'd5;
  localparam logic [3:0] ROpSrl = 4'd6;
  localparam logic [3:0] ROpSra = 4'd7;
  localparam logic [3:0] ROpOr  = 4'd8;
  localparam logic [3:0] ROpAnd = 4'd9;

  localparam logic [3:0] IOpAddi  = 4'd1;
  localparam logic [3:0] IOpSlti  = 4'd2;
  localparam logic [3:0] IOpSltiu = 4'd3;
  localparam logic [3:0] IOpXori  = 4'd4;
  localparam logic [3:0] IOpOri   = 4'd5;
  localparam logic [3:0] IOpAndi  = 4'd6;
  localparam logic [3:0] IOpSlli  = 4'd7;
  localparam logic [3:0] IOpSrli  = 4'd8;
  localparam logic [3:0] IOpSrai  = 4'd9;

  localparam logic [3:0] LOpLb  = 4'd0;
  localparam logic [3:0] LOpLh  = 4'd1;
  localparam logic [3:0] LOpLw  = 4'd2;
  localparam logic [3:0] LOpLbu = 4'd3;
  localparam logic [3:0] LOpLhu = 4'd4;

  localparam logic [3:0] SOpSb = 4'd0;
  localparam logic [3:0] SOpSh = 4'd1;
  localparam logic [3:0] SOpSw = 4'd2;

  localparam logic [3:0] BOpBeq  = 4'd0;
  localparam logic [3:0] BOpBne  = 4'd1;
  localparam logic [3:0] BOpBlt  = 4'd2;
  localparam logic [3:0] BOpBge  = 4'd3;
  localparam logic [3:0] BOpBltu = 4'd4;
  localparam logic [3:0] BOpBgeu = 4'd5;

  localparam logic [6:0] OpcR = 7'b0110011;
  localparam logic [6:0] OpcI = 7'b0010011;
  localparam logic [6:0] OpcL = 7'b0000011;
  localparam logic [6:0] OpcS = 7'b0100011;
  localparam logic [6:0] OpcB = 7'b1100011;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3SrlSra = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  localparam logic [31:0] Nop = 32'h0000_0013;

  function automatic logic fits_s12(logic [31:0] imm);
    return (imm[31:11] == '0) || (imm[31:11] == '1);
  endfunction

  function automatic logic fits_s13(logic [31:0] imm);
    return (imm[31:12] == '0) || (imm[31:12] == '1);
  endfunction

endpackage

// File: rtl/rv32_instr_encoder_if.sv
// Request and encoded-word handshake bundle for the RV32I encoder.
interface rv32_instr_encoder_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_class;
    logic [3:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_class, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, in_class, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/rv32_field_pack.sv
// Combinational packing of a symbolic request into an RV32I word; illegal
// requests yield a NOP and raise illegal_o.
module rv32_field_pack
    import rv32_enc_pkg::*;
(
    input  logic [2:0]  class_i,
    input  logic [3:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        illegal_o
);

    logic [31:0] raw;
    logic        bad;
    logic        shift;
    logic [2:0]  f3;
    logic [6:0]  f7;

    always_comb begin
        raw   = Nop;
        bad   = 1'b0;
        shift = 1'b0;
        f3    = 3'b000;
        f7    = F7Base;
        case (class_i)
            ClsR: begin
                case (op_i)
                    ROpAdd:  f3 = F3AddSub;
                    ROpSub:  begin f3 = F3AddSub; f7 = F7Alt; end
                    ROpSll:  f3 = F3Sll;
                    ROpSlt:  f3 = F3Slt;
                    ROpXor:  f3 = F3Xor;
                    ROpSrl:  f3 = F3SrlSra;
                    ROpSra:  begin f3 = F3SrlSra; f7 = F7Alt; end
                    ROpOr:   f3 = F3Or;
                    ROpAnd:  f3 = F3And;
                    default: bad = 1'b1;
                endcase
                raw = {f7, rs2_i, rs1_i, f3, rd_i, OpcR};
            end
            ClsI: begin
                case (op_i)
                    IOpAddi:  f3 = F3AddSub;
                    IOpSlti:  f3 = F3Slt;
                    IOpSltiu: f3 = F3Sltu;
                    IOpXori:  f3 = F3Xor;
                    IOpOri:   f3 = F3Or;
                    IOpAndi:  f3 = F3And;
                    IOpSlli:  begin f3 = F3Sll; shift = 1'b1; end
                    IOpSrli:  begin f3 = F3SrlSra; shift = 1'b1; end
                    IOpSrai:  begin f3 = F3SrlSra; shift = 1'b1; f7 = F7Alt; end
                    default:  bad = 1'b1;
                endcase
                if (shift) begin
                    bad = bad | (imm_i[31:5] != '0);
                    raw = {f7, imm_i[4:0], rs1_i, f3, rd_i, OpcI};
                end else begin
                    bad = bad | !fits_s12(imm_i);
                    raw = {imm_i[11:0], rs1_i, f3, rd_i, OpcI};
                end
            end
            ClsL: begin
                case (op_i)
                    LOpLb:   f3 = F3Byte;
                    LOpLh:   f3 = F3Half;
                    LOpLw:   f3 = F3Word;
                    LOpLbu:  f3 = F3ByteU;
                    LOpLhu:  f3 = F3HalfU;
                    default: bad = 1'b1;
                endcase
                bad = bad | !fits_s12(imm_i);
                raw = {imm_i[11:0], rs1_i, f3, rd_i, OpcL};
            end
            ClsS: begin
                case (op_i)
                    SOpSb:   f3 = F3Byte;
                    SOpSh:   f3 = F3Half;
                    SOpSw:   f3 = F3Word;
                    default: bad = 1'b1;
                endcase
                bad = bad | !fits_s12(imm_i);
                raw = {imm_i[11:5], rs2_i, rs1_i, f3, imm_i[4:0], OpcS};
            end
            ClsB: begin
                case (op_i)
                    BOpBeq:  f3 = F3Beq;
                    BOpBne:  f3 = F3Bne;
                    BOpBlt:  f3 = F3Blt;
                    BOpBge:  f3 = F3Bge;
                    BOpBltu: f3 = F3Bltu;
                    BOpBgeu: f3 = F3Bgeu;
                    default: bad = 1'b1;
                endcase
                // Branch offsets are halfword aligned; bit 0 is not encodable.
                bad = bad | !fits_s13(imm_i) | imm_i[0];
                raw = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3, imm_i[4:1], imm_i[11], OpcB};
            end
            default: bad = 1'b1;
        endcase
        instr_o   = bad ? Nop : raw;
        illegal_o = bad;
    end

endmodule

// File: rtl/rv32_instr_encoder.sv
// RV32I instruction encoder: one registered output stage, sequential word
// addressing with a full limit, and a sticky illegal-request flag.
module rv32_instr_encoder
    import rv32_enc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst,
    rv32_instr_encoder_if.slave bus,
    input  logic              clear,
    output logic              full,
    output logic              err_illegal,
    output logic [ADDR_W-1:0] word_count
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              full_q, full_d;
    logic              err_q, err_d;

    logic [31:0]       packed_instr;
    logic              packed_illegal;
    logic              accept;
    logic              handshake;
    logic              room;
    logic [ADDR_W:0]   committed;
    logic [ADDR_W:0]   count_inc;
    logic [ADDR_W-1:0] eff_next;

    rv32_field_pack u_pack (
        .class_i   (bus.in_class),
        .op_i      (bus.in_op),
        .rd_i      (bus.in_rd),
        .rs1_i     (bus.in_rs1),
        .rs2_i     (bus.in_rs2),
        .imm_i     (bus.in_imm),
        .instr_o   (packed_instr),
        .illegal_o (packed_illegal)
    );

    // A word in the output register already owns one of the DEPTH slots, so
    // stop accepting once delivered + pending would exceed the limit.
    assign committed = {1'b0, count_q} + {{ADDR_W{1'b0}}, out_valid_q};
    assign room      = committed < DepthW;
    assign count_inc = {1'b0, count_q} + {{ADDR_W{1'b0}}, 1'b1};

    assign bus.in_ready = !full_q && (!out_valid_q || bus.out_ready) && room;
    assign accept       = bus.in_valid && bus.in_ready;
    assign handshake    = out_valid_q && bus.out_ready;
    assign eff_next     = clear ? BaseAddr : next_addr_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        next_addr_d = eff_next;
        count_d     = count_q;
        full_d      = full_q;
        err_d       = err_q;

        if (handshake) begin
            out_valid_d = 1'b0;
            out_addr_d  = eff_next;
            count_d     = count_inc[ADDR_W-1:0];
            if (count_inc == DepthW) full_d = 1'b1;
        end else if (clear && !out_valid_q) begin
            out_addr_d = BaseAddr;
        end

        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = packed_instr;
            out_addr_d  = eff_next;
            next_addr_d = eff_next + ADDR_W'(4);
            if (packed_illegal) err_d = 1'b1;
        end

        if (clear) begin
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BaseAddr;
            next_addr_q <= BaseAddr;
            count_q     <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            next_addr_q <= next_addr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;
    assign full          = full_q;
    assign err_illegal   = err_q;
    assign word_count    = count_q;

endmodule
